// File: rtl/rv32_fetch_decode_execute.sv
// -----------------------------------------------------------------------------
// rv32_fetch_decode_execute
//
// Combinational RV32I fetch/decode/execute datapath for the single-cycle core.
// It holds the fetched instruction, splits it into fields, builds the
// immediate and type flags, and computes the writeback value, next PC and CSR
// write request. The instruction-hold register is the only state.
//
// Ports
//   clk          in   clock; the hold register samples on the rising edge
//   rst          in   asynchronous reset, active-low
//   pc           in   PC of the current instruction
//   imem_rdata   in   fetched instruction word
//   imem_rvalid  in   imem_rdata is valid this cycle
//   rs1_data     in   GPR read data for rs1
//   rs2_data     in   GPR read data for rs2
//   csr_rdata    in   CSR read data for csr_addr
//   mepc, mtvec  in   current trap return / trap vector addresses
//   inst         out  current instruction
//   opcode, funct3, funct7, rs1_addr, rs2_addr, rd_addr, csr_addr
//                out  decoded instruction fields
//   imm          out  sign-extended immediate (0 for R-type)
//   is_load, is_store, is_ecall
//                out  instruction type flags
//   inst_invalid out  unsupported encoding
//   reg_write_en out  request to write rd
//   result       out  writeback value, or memory address for loads/stores
//   next_pc      out  PC of the next instruction
//   csr_we       out  CSR write request
//   csr_wdata    out  CSR write data
// -----------------------------------------------------------------------------
module rv32_fetch_decode_execute (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc,
    input  logic [31:0] imem_rdata,
    input  logic        imem_rvalid,
    input  logic [31:0] rs1_data,
    input  logic [31:0] rs2_data,
    input  logic [31:0] csr_rdata,
    input  logic [31:0] mepc,
    input  logic [31:0] mtvec,
    output logic [31:0] inst,
    output logic [6:0]  opcode,
    output logic [2:0]  funct3,
    output logic [6:0]  funct7,
    output logic [4:0]  rs1_addr,
    output logic [4:0]  rs2_addr,
    output logic [4:0]  rd_addr,
    output logic [31:0] imm,
    output logic [11:0] csr_addr,
    output logic        is_load,
    output logic        is_store,
    output logic        is_ecall,
    output logic        inst_invalid,
    output logic        reg_write_en,
    output logic [31:0] result,
    output logic [31:0] next_pc,
    output logic        csr_we,
    output logic [31:0] csr_wdata
);

    localparam logic [31:0] NOP_WORD    = 32'h0000_0013;
    localparam logic [31:0] ECALL_WORD  = 32'h0000_0073;
    localparam logic [31:0] EBREAK_WORD = 32'h0010_0073;
    localparam logic [31:0] MRET_WORD   = 32'h3020_0073;

    typedef enum logic [6:0] {
        OPC_LUI    = 7'b0110111,
        OPC_AUIPC  = 7'b0010111,
        OPC_JAL    = 7'b1101111,
        OPC_JALR   = 7'b1100111,
        OPC_BRANCH = 7'b1100011,
        OPC_LOAD   = 7'b0000011,
        OPC_STORE  = 7'b0100011,
        OPC_OP_IMM = 7'b0010011,
        OPC_OP     = 7'b0110011,
        OPC_SYSTEM = 7'b1110011
    } opcode_e;

    // -------------------------------------------------------------------------
    // Fetch: hold register keeps the last valid word while imem_rvalid is low
    // -------------------------------------------------------------------------
    logic [31:0] inst_hold_d;
    logic [31:0] inst_hold_q;

    always_comb begin
        inst_hold_d = imem_rvalid ? imem_rdata : inst_hold_q;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value regardless of process ordering.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inst_hold_q <= NOP_WORD;
        end else begin
            inst_hold_q <= inst_hold_d;
        end
    end

    // Reset forces a nop straight through, not just into the hold register.
    always_comb begin
        if (!rst) begin
            inst = NOP_WORD;
        end else if (imem_rvalid) begin
            inst = imem_rdata;
        end else begin
            inst = inst_hold_q;
        end
    end

    // -------------------------------------------------------------------------
    // Field extraction and immediate formats
    // -------------------------------------------------------------------------
    assign opcode   = inst[6:0];
    assign rd_addr  = inst[11:7];
    assign funct3   = inst[14:12];
    assign rs1_addr = inst[19:15];
    assign rs2_addr = inst[24:20];
    assign funct7   = inst[31:25];
    assign csr_addr = inst[31:20];

    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    assign imm_i = {{20{inst[31]}}, inst[31:20]};
    assign imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
    assign imm_b = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    assign imm_u = {inst[31:12], 12'b0};
    assign imm_j = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

    // NOTE: every combinational process assigns a default to each output
    // first, so no path through the case statements can infer a latch.
    always_comb begin
        imm = 32'd0;
        case (opcode)
            OPC_LUI, OPC_AUIPC:                      imm = imm_u;
            OPC_JAL:                                 imm = imm_j;
            OPC_JALR, OPC_LOAD, OPC_OP_IMM, OPC_SYSTEM: imm = imm_i;
            OPC_BRANCH:                              imm = imm_b;
            OPC_STORE:                               imm = imm_s;
            default:                                 imm = 32'd0;
        endcase
    end

    // -------------------------------------------------------------------------
    // Encoding legality
    // -------------------------------------------------------------------------
    logic dec_valid;

    always_comb begin
        dec_valid = 1'b0;
        case (opcode)
            OPC_LUI, OPC_AUIPC, OPC_JAL: dec_valid = 1'b1;
            OPC_JALR:   dec_valid = (funct3 == 3'b000);
            OPC_BRANCH: dec_valid = (funct3 != 3'b010) && (funct3 != 3'b011);
            OPC_LOAD:   dec_valid = funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
            OPC_STORE:  dec_valid = funct3 inside {3'b000, 3'b001, 3'b010};
            OPC_OP_IMM: begin
                case (funct3)
                    3'b001:  dec_valid = (funct7 == 7'h00);
                    3'b101:  dec_valid = (funct7 == 7'h00) || (funct7 == 7'h20);
                    default: dec_valid = 1'b1;
                endcase
            end
            // Only ADD/SUB and SRL/SRA have an alternate (0x20) funct7.
            OPC_OP: dec_valid = (funct7 == 7'h00) ||
                                ((funct7 == 7'h20) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
            OPC_SYSTEM: begin
                if (funct3 == 3'b000) begin
                    dec_valid = (inst == ECALL_WORD) || (inst == EBREAK_WORD) ||
                                (inst == MRET_WORD);
                end else begin
                    dec_valid = (funct3 != 3'b100);
                end
            end
            default: dec_valid = 1'b0;
        endcase
    end

    // -------------------------------------------------------------------------
    // ALU, branch compare and shared adders
    // -------------------------------------------------------------------------
    logic [31:0] pc_plus_4;
    logic [31:0] pc_plus_imm;
    logic [31:0] rs1_plus_imm;
    logic [31:0] alu_b;
    logic [4:0]  shamt;
    logic        lt_signed;
    logic        lt_unsigned;
    logic [31:0] alu_out;
    logic        branch_taken;

    assign pc_plus_4    = pc + 32'd4;
    assign pc_plus_imm  = pc + imm;
    assign rs1_plus_imm = rs1_data + imm;

    // OP-IMM takes the immediate; its shamt is inst[24:20] = imm[4:0].
    assign alu_b       = (opcode == OPC_OP) ? rs2_data : imm;
    assign shamt       = alu_b[4:0];
    assign lt_signed   = $signed(rs1_data) < $signed(alu_b);
    assign lt_unsigned = rs1_data < alu_b;

    always_comb begin
        alu_out = 32'd0;
        case (funct3)
            3'b000: alu_out = ((opcode == OPC_OP) && funct7[5]) ? (rs1_data - alu_b)
                                                                : (rs1_data + alu_b);
            3'b001: alu_out = rs1_data << shamt;
            3'b010: alu_out = {31'd0, lt_signed};
            3'b011: alu_out = {31'd0, lt_unsigned};
            3'b100: alu_out = rs1_data ^ alu_b;
            3'b101: alu_out = funct7[5] ? 32'($signed(rs1_data) >>> shamt)
                                        : (rs1_data >> shamt);
            3'b110: alu_out = rs1_data | alu_b;
            3'b111: alu_out = rs1_data & alu_b;
            default: alu_out = 32'd0;
        endcase
    end

    // Branches compare rs1 against rs2 directly, independent of alu_b.
    always_comb begin
        branch_taken = 1'b0;
        case (funct3)
            3'b000: branch_taken = (rs1_data == rs2_data);
            3'b001: branch_taken = (rs1_data != rs2_data);
            3'b100: branch_taken = ($signed(rs1_data) <  $signed(rs2_data));
            3'b101: branch_taken = ($signed(rs1_data) >= $signed(rs2_data));
            3'b110: branch_taken = (rs1_data <  rs2_data);
            3'b111: branch_taken = (rs1_data >= rs2_data);
            default: branch_taken = 1'b0;
        endcase
    end

    // -------------------------------------------------------------------------
    // CSR read-modify-write
    // -------------------------------------------------------------------------
    logic [31:0] csr_src;

    assign csr_src = funct3[2] ? {27'd0, rs1_addr} : rs1_data;

    always_comb begin
        csr_wdata = csr_rdata;
        case (funct3[1:0])
            2'b01:   csr_wdata = csr_src;
            2'b10:   csr_wdata = csr_rdata | csr_src;
            2'b11:   csr_wdata = csr_rdata & ~csr_src;
            default: csr_wdata = csr_rdata;
        endcase
    end

    // -------------------------------------------------------------------------
    // Execute: writeback value, next PC and side-effect requests
    // -------------------------------------------------------------------------
    logic [31:0] exec_next_pc;
    logic        exec_writes_rd;
    logic        exec_csr_write;
    logic        exec_load;
    logic        exec_store;
    logic        exec_ecall;

    always_comb begin
        result         = 32'd0;
        exec_next_pc   = pc_plus_4;
        exec_writes_rd = 1'b0;
        exec_csr_write = 1'b0;
        exec_load      = 1'b0;
        exec_store     = 1'b0;
        exec_ecall     = 1'b0;
        case (opcode)
            OPC_LUI: begin
                result         = imm;
                exec_writes_rd = 1'b1;
            end
            OPC_AUIPC: begin
                result         = pc_plus_imm;
                exec_writes_rd = 1'b1;
            end
            OPC_JAL: begin
                result         = pc_plus_4;
                exec_next_pc   = pc_plus_imm;
                exec_writes_rd = 1'b1;
            end
            OPC_JALR: begin
                result         = pc_plus_4;
                exec_next_pc   = rs1_plus_imm & 32'hFFFF_FFFE;
                exec_writes_rd = 1'b1;
            end
            OPC_BRANCH: begin
                exec_next_pc = branch_taken ? pc_plus_imm : pc_plus_4;
            end
            OPC_LOAD: begin
                result         = rs1_plus_imm;
                exec_writes_rd = 1'b1;
                exec_load      = 1'b1;
            end
            OPC_STORE: begin
                result     = rs1_plus_imm;
                exec_store = 1'b1;
            end
            OPC_OP, OPC_OP_IMM: begin
                result         = alu_out;
                exec_writes_rd = 1'b1;
            end
            OPC_SYSTEM: begin
                if (funct3 == 3'b000) begin
                    // ECALL/MRET only redirect; the core owns trap CSR updates.
                    if (inst == ECALL_WORD) begin
                        exec_ecall   = 1'b1;
                        exec_next_pc = mtvec;
                    end else if (inst == MRET_WORD) begin
                        exec_next_pc = mepc;
                    end
                end else begin
                    result         = csr_rdata;
                    exec_writes_rd = 1'b1;
                    // Set/clear with a zero rs1 field is a pure read.
                    exec_csr_write = !(funct3[1] && (rs1_addr == 5'd0));
                end
            end
            default: begin
                result = 32'd0;
            end
        endcase
    end

    assign inst_invalid = !dec_valid;
    assign reg_write_en = dec_valid && exec_writes_rd && (rd_addr != 5'd0);
    assign csr_we       = dec_valid && exec_csr_write;
    assign is_load      = dec_valid && exec_load;
    assign is_store     = dec_valid && exec_store;
    assign is_ecall     = dec_valid && exec_ecall;
    assign next_pc      = dec_valid ? exec_next_pc : pc_plus_4;

endmodule

// File: tb/tb_rv32_fetch_decode_execute.sv
// -----------------------------------------------------------------------------
// tb_rv32_fetch_decode_execute
//
// Directed bench: a table of instruction vectors with hand-computed expected
// outputs, plus hand-written sequences for reset, hold and async reset.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_rv32_fetch_decode_execute;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc;
    logic [31:0] imem_rdata;
    logic        imem_rvalid;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] csr_rdata;
    logic [31:0] mepc;
    logic [31:0] mtvec;
    logic [31:0] inst;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [4:0]  rd_addr;
    logic [31:0] imm;
    logic [11:0] csr_addr;
    logic        is_load;
    logic        is_store;
    logic        is_ecall;
    logic        inst_invalid;
    logic        reg_write_en;
    logic [31:0] result;
    logic [31:0] next_pc;
    logic        csr_we;
    logic [31:0] csr_wdata;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rv32_fetch_decode_execute dut (
        .clk          (clk),
        .rst          (rst),
        .pc           (pc),
        .imem_rdata   (imem_rdata),
        .imem_rvalid  (imem_rvalid),
        .rs1_data     (rs1_data),
        .rs2_data     (rs2_data),
        .csr_rdata    (csr_rdata),
        .mepc         (mepc),
        .mtvec        (mtvec),
        .inst         (inst),
        .opcode       (opcode),
        .funct3       (funct3),
        .funct7       (funct7),
        .rs1_addr     (rs1_addr),
        .rs2_addr     (rs2_addr),
        .rd_addr      (rd_addr),
        .imm          (imm),
        .csr_addr     (csr_addr),
        .is_load      (is_load),
        .is_store     (is_store),
        .is_ecall     (is_ecall),
        .inst_invalid (inst_invalid),
        .reg_write_en (reg_write_en),
        .result       (result),
        .next_pc      (next_pc),
        .csr_we       (csr_we),
        .csr_wdata    (csr_wdata)
    );

    // flags = {inst_invalid, reg_write_en, csr_we, is_load, is_store, is_ecall}
    typedef struct {
        logic [31:0] word;
        logic [31:0] pc;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] csr;
        logic [31:0] exp_result;
        logic [31:0] exp_next_pc;
        logic [31:0] exp_imm;
        logic [31:0] exp_wdata;
        logic [5:0]  exp_flags;
        bit          chk_ri;
        bit          chk_wd;
    } vec_t;

    localparam int NVEC = 24;
    vec_t vecs [NVEC];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] flags_now();
        return {26'd0, inst_invalid, reg_write_en, csr_we, is_load, is_store, is_ecall};
    endfunction

    initial begin
        //            word          pc            rs1           rs2           csr           result        next_pc       imm           wdata         flags     ri wd
        vecs[0]  = '{32'hFFF00093, 32'h80000000, 32'h00000000, 32'h0,        32'h0,        32'hFFFFFFFF, 32'h80000004, 32'hFFFFFFFF, 32'h0,        6'b010000, 1, 0}; // ADDI x1,x0,-1
        vecs[1]  = '{32'hFE209CE3, 32'h80000010, 32'h00000001, 32'h00000002, 32'h0,        32'h0,        32'h80000008, 32'hFFFFFFF8, 32'h0,        6'b000000, 1, 0}; // BNE taken
        vecs[2]  = '{32'hFE209CE3, 32'h80000010, 32'h00000005, 32'h00000005, 32'h0,        32'h0,        32'h80000014, 32'hFFFFFFF8, 32'h0,        6'b000000, 1, 0}; // BNE not taken
        vecs[3]  = '{32'h004280E7, 32'h80000020, 32'h80000101, 32'h0,        32'h0,        32'h80000024, 32'h80000104, 32'h00000004, 32'h0,        6'b010000, 1, 0}; // JALR x1,4(x5)
        vecs[4]  = '{32'h00000073, 32'h80000000, 32'h0,        32'h0,        32'h0,        32'h0,        32'h80001000, 32'h0,        32'h0,        6'b000001, 1, 0}; // ECALL
        vecs[5]  = '{32'h30200073, 32'h80000000, 32'h0,        32'h0,        32'h0,        32'h0,        32'h80000020, 32'h00000302, 32'h0,        6'b000000, 1, 0}; // MRET
        vecs[6]  = '{32'h30002173, 32'h80000000, 32'h0,        32'h0,        32'h00001888, 32'h00001888, 32'h80000004, 32'h00000300, 32'h00001888, 6'b010000, 1, 1}; // CSRRS x2,mstatus,x0
        vecs[7]  = '{32'h300231F3, 32'h80000000, 32'h00000008, 32'h0,        32'h00001888, 32'h00001888, 32'h80000004, 32'h00000300, 32'h00001880, 6'b011000, 1, 1}; // CSRRC x3,mstatus,x4
        vecs[8]  = '{32'hFFFFFFFF, 32'h80000000, 32'h11111111, 32'h22222222, 32'h33333333, 32'h0,        32'h80000004, 32'h0,        32'h0,        6'b100000, 0, 0}; // unknown opcode
        vecs[9]  = '{32'h123452B7, 32'h80000000, 32'h0,        32'h0,        32'h0,        32'h12345000, 32'h80000004, 32'h12345000, 32'h0,        6'b010000, 1, 0}; // LUI
        vecs[10] = '{32'hFFFFF317, 32'h80000000, 32'h0,        32'h0,        32'h0,        32'h7FFFF000, 32'h80000004, 32'hFFFFF000, 32'h0,        6'b010000, 1, 0}; // AUIPC
        vecs[11] = '{32'h010000EF, 32'hFFFFFFF8, 32'h0,        32'h0,        32'h0,        32'hFFFFFFFC, 32'h00000008, 32'h00000010, 32'h0,        6'b010000, 1, 0}; // JAL wraps
        vecs[12] = '{32'hFFC42383, 32'h80000000, 32'h00001000, 32'h0,        32'h0,        32'h00000FFC, 32'h80000004, 32'hFFFFFFFC, 32'h0,        6'b010100, 1, 0}; // LW x7,-4(x8)
        vecs[13] = '{32'h00952423, 32'h80000000, 32'h00002000, 32'h0,        32'h0,        32'h00002008, 32'h80000004, 32'h00000008, 32'h0,        6'b000010, 1, 0}; // SW x9,8(x10)
        vecs[14] = '{32'h40D605B3, 32'h80000000, 32'h00000005, 32'h00000007, 32'h0,        32'hFFFFFFFE, 32'h80000004, 32'h0,        32'h0,        6'b010000, 1, 0}; // SUB
        vecs[15] = '{32'h403150B3, 32'h80000000, 32'h80000000, 32'h00000024, 32'h0,        32'hF8000000, 32'h80000004, 32'h0,        32'h0,        6'b010000, 1, 0}; // SRA, shamt low 5
        vecs[16] = '{32'h003130B3, 32'h80000000, 32'h00000001, 32'hFFFFFFFF, 32'h0,        32'h00000001, 32'h80000004, 32'h0,        32'h0,        6'b010000, 1, 0}; // SLTU
        vecs[17] = '{32'h003120B3, 32'h80000000, 32'h00000001, 32'hFFFFFFFF, 32'h0,        32'h00000000, 32'h80000004, 32'h0,        32'h0,        6'b010000, 1, 0}; // SLT
        vecs[18] = '{32'h40415093, 32'h80000000, 32'h80000000, 32'h0,        32'h0,        32'hF8000000, 32'h80000004, 32'h00000404, 32'h0,        6'b010000, 1, 0}; // SRAI
        vecs[19] = '{32'h023100B3, 32'h80000000, 32'h00000003, 32'h00000004, 32'h0,        32'h0,        32'h80000004, 32'h0,        32'h0,        6'b100000, 0, 0}; // OP funct7 0x01
        vecs[20] = '{32'h00002063, 32'h80000000, 32'h0,        32'h0,        32'h0,        32'h0,        32'h80000004, 32'h0,        32'h0,        6'b100000, 0, 0}; // branch funct3 010
        vecs[21] = '{32'h3052D0F3, 32'h80000000, 32'h0000FFFF, 32'h0,        32'h0000AAAA, 32'h0000AAAA, 32'h80000004, 32'h00000305, 32'h00000005, 6'b011000, 1, 1}; // CSRRWI x1,0x305,5
        vecs[22] = '{32'h00100073, 32'h80000000, 32'h0,        32'h0,        32'h0,        32'h0,        32'h80000004, 32'h00000001, 32'h0,        6'b000000, 1, 0}; // EBREAK
        vecs[23] = '{32'h40411093, 32'h80000000, 32'h0,        32'h0,        32'h0,        32'h0,        32'h80000004, 32'h0,        32'h0,        6'b100000, 0, 0}; // SLLI funct7 0x20

        mepc        = 32'h80000020;
        mtvec       = 32'h80001000;
        csr_rdata   = 32'h0;
        rs2_data    = 32'h0;

        // ---- Reset state ----------------------------------------------------
        rst         = 1'b0;
        pc          = 32'h80000000;
        rs1_data    = 32'h00001234;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hFFF00093;
        #1;
        check("rst.inst",    inst,         32'h00000013);
        check("rst.next_pc", next_pc,      32'h80000004);
        check("rst.result",  result,       32'h00001234);
        check("rst.flags",   flags_now(),  32'h0);
        repeat (2) @(posedge clk);

        // ---- ADDI then hold when imem_rvalid drops --------------------------
        @(negedge clk);
        rst         = 1'b1;
        rs1_data    = 32'h0;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hFFF00093;
        #1;
        check("addi.result", result,             32'hFFFFFFFF);
        check("addi.rd",     32'(rd_addr),       32'd1);
        check("addi.rwe",    32'(reg_write_en),  32'd1);
        @(posedge clk);
        @(negedge clk);
        imem_rvalid = 1'b0;
        imem_rdata  = 32'hFE209CE3;
        #1;
        check("hold.inst",   inst,               32'hFFF00093);
        check("hold.result", result,             32'hFFFFFFFF);
        check("hold.rd",     32'(rd_addr),       32'd1);
        check("hold.rwe",    32'(reg_write_en),  32'd1);
        @(posedge clk);
        #1;
        check("hold2.inst",  inst,               32'hFFF00093);

        // ---- Asynchronous reset mid-operation clears the hold register ------
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("arst.inst",   inst,               32'h00000013);
        check("arst.rwe",    32'(reg_write_en),  32'd0);
        rst = 1'b1;
        #1;
        check("arst.hold",   inst,               32'h00000013);

        // ---- Table-driven vectors -------------------------------------------
        for (int i = 0; i < NVEC; i++) begin
            @(negedge clk);
            imem_rvalid = 1'b1;
            imem_rdata  = vecs[i].word;
            pc          = vecs[i].pc;
            rs1_data    = vecs[i].rs1;
            rs2_data    = vecs[i].rs2;
            csr_rdata   = vecs[i].csr;
            #1;
            check($sformatf("v%0d.inst", i),    inst,        vecs[i].word);
            check($sformatf("v%0d.next_pc", i), next_pc,     vecs[i].exp_next_pc);
            check($sformatf("v%0d.flags", i),   flags_now(), {26'd0, vecs[i].exp_flags});
            if (vecs[i].chk_ri) begin
                check($sformatf("v%0d.result", i), result, vecs[i].exp_result);
                check($sformatf("v%0d.imm", i),    imm,    vecs[i].exp_imm);
            end
            if (vecs[i].chk_wd) begin
                check($sformatf("v%0d.csr_wdata", i), csr_wdata, vecs[i].exp_wdata);
            end
        end

        // ---- Field extraction on SUB x11,x12,x13 ----------------------------
        @(negedge clk);
        imem_rdata = 32'h40D605B3;
        #1;
        check("fld.opcode",   32'(opcode),   32'h33);
        check("fld.funct3",   32'(funct3),   32'h0);
        check("fld.funct7",   32'(funct7),   32'h20);
        check("fld.rs1",      32'(rs1_addr), 32'd12);
        check("fld.rs2",      32'(rs2_addr), 32'd13);
        check("fld.rd",       32'(rd_addr),  32'd11);
        check("fld.csr_addr", 32'(csr_addr), 32'h40D);

        // ---- rd = x0 suppresses write enable --------------------------------
        @(negedge clk);
        imem_rdata = 32'h00100013; // ADDI x0,x0,1
        rs1_data   = 32'h00000010;
        #1;
        check("x0.result", result,            32'h00000011);
        check("x0.rwe",    32'(reg_write_en), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rv32_fetch_decode_execute.md
# rv32_fetch_decode_execute

Combinational RV32I fetch/decode/execute datapath for the single-cycle core. It sits between the instruction memory port, the register file and CSR file, and the LSU. It holds the fetched instruction, decodes it into fields, immediates and type flags, and computes the ALU result, next PC and CSR write request. The instruction-hold register is the only state.

## Interface
- No parameters.
- `clk` in 1: clock; the hold register samples on the rising edge.
- `rst` in 1: asynchronous reset, active-low.
- `pc` in 32: PC of the current instruction.
- `imem_rdata` in 32: fetched instruction word.
- `imem_rvalid` in 1: `imem_rdata` is valid this cycle.
- `rs1_data`, `rs2_data` in 32: GPR read data.
- `csr_rdata` in 32: CSR read data for `csr_addr`.
- `mepc`, `mtvec` in 32: current MEPC and MTVEC values.
- `inst` out 32: current instruction.
- `opcode` out 7, `funct3` out 3, `funct7` out 7: instruction fields.
- `rs1_addr`, `rs2_addr`, `rd_addr` out 5: register indices.
- `imm` out 32: sign-extended immediate; 0 for R-type.
- `csr_addr` out 12: `inst[31:20]`.
- `is_load`, `is_store`, `is_ecall` out 1: instruction type flags.
- `inst_invalid` out 1: unsupported encoding.
- `reg_write_en` out 1: request to write `rd`.
- `result` out 32: writeback value, or memory address for loads and stores.
- `next_pc` out 32: PC of the next instruction.
- `csr_we` out 1, `csr_wdata` out 32: CSR write request for `csr_addr`.

## Operation
- Fetch
  - While `rst` = 0: `inst` = 0x00000013 (nop) and the hold register = 0x00000013.
  - Otherwise, if `imem_rvalid` = 1: `inst` = `imem_rdata`.
  - Otherwise: `inst` = the hold register.
  - The hold register loads `imem_rdata` on each edge where `imem_rvalid` = 1.
- Decode fields: opcode [6:0], rd [11:7], funct3 [14:12], rs1 [19:15], rs2 [24:20], funct7 [31:25].
- Immediates: I, S, B, U and J formats, sign-extended from bit 31. B and J immediates have bit 0 = 0. The U immediate is `inst[31:12]` followed by 12 zero bits.
- Supported instructions:
  - LUI, AUIPC, JAL, JALR.
  - BEQ, BNE, BLT, BGE, BLTU, BGEU.
  - LB, LH, LW, LBU, LHU; SB, SH, SW.
  - OP-IMM: ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI.
  - OP: ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND.
  - SYSTEM: ECALL, EBREAK, MRET, CSRRW, CSRRS, CSRRC, CSRRWI, CSRRSI, CSRRCI.
- Any other encoding sets `inst_invalid` = 1. This includes a bad funct3, a bad funct7 (only 0x00 and 0x20 are accepted where applicable) and an unknown opcode.
- While `inst_invalid` = 1:
  - `reg_write_en` = 0, `csr_we` = 0.
  - `is_load`, `is_store`, `is_ecall` = 0.
  - `next_pc` = `pc` + 4.
- `result` by instruction type:
  - LUI: `imm`. AUIPC: `pc` + `imm`.
  - JAL, JALR: `pc` + 4.
  - Loads and stores: `rs1_data` + `imm`.
  - OP/OP-IMM: ALU result. Shift amounts use the low 5 bits. SLT is signed, SLTU unsigned.
  - CSR instructions: `csr_rdata`.
  - Branches and other SYSTEM: 0.
- `reg_write_en` = 1 for LUI, AUIPC, JAL, JALR, loads, OP, OP-IMM and CSR instructions, and only when `rd` ≠ 0.
- CSR writes: the source is `rs1_data`, or the zero-extended `rs1` field for the `*I` forms.
  - RW: `csr_wdata` = source.
  - RS: `csr_wdata` = `csr_rdata` OR source.
  - RC: `csr_wdata` = `csr_rdata` AND NOT source.
  - `csr_we` = 1, except RS and RC with `rs1` field = 0, which give `csr_we` = 0.
  - ECALL and MRET give `csr_we` = 0; trap CSR updates belong to the core.
- `next_pc`:
  - JAL: `pc` + `imm`. JALR: (`rs1_data` + `imm`) AND 0xFFFFFFFE.
  - Taken branch: `pc` + `imm`; not taken: `pc` + 4.
  - ECALL: `mtvec`. MRET: `mepc`.
  - All other instructions: `pc` + 4.
- EBREAK is valid and has no write side effects.
- All address and PC arithmetic wraps modulo 2^32.

## Timing
- Every output is combinational from `inst`, `pc` and the data inputs; latency is zero cycles.
- The only sequential element is the hold register, updated on the rising edge when `imem_rvalid` = 1.
- When `rst` is asserted mid-operation, the hold register clears immediately (asynchronously) and all outputs decode the nop.
  - Reset output values: `inst` = 0x00000013, `next_pc` = `pc` + 4, `result` = `rs1_data`.
  - All enables and flags are 0.
- When `imem_rvalid` falls, outputs continue to decode the last valid instruction.

## Test plan
- Reset: `rst` = 0, `pc` = 0x80000000 -> `inst` = 0x00000013, `next_pc` = 0x80000004, `reg_write_en` = 0.
- ADDI x1,x0,-1 (0xFFF00093), `rs1_data` = 0 -> `result` = 0xFFFFFFFF, `rd_addr` = 1, `reg_write_en` = 1. Drop `imem_rvalid` and change `imem_rdata` -> outputs unchanged.
- BNE with `rs1_data` = 1, `rs2_data` = 2, `imm` = -8, `pc` = 0x80000010 -> `next_pc` = 0x80000008. Repeat with equal operands -> `next_pc` = 0x80000014.
- JALR x1,4(x5) with `rs1_data` = 0x80000101 -> `next_pc` = 0x80000104, `result` = `pc` + 4.
- ECALL with `mtvec` = 0x80001000 -> `is_ecall` = 1, `next_pc` = 0x80001000, `csr_we` = 0. MRET with `mepc` = 0x80000020 -> `next_pc` = 0x80000020.
- CSRRS x2,mstatus,x0 -> `csr_we` = 0, `result` = `csr_rdata`. CSRRC with `rs1_data` = 0x8 and `csr_rdata` = 0x1888 -> `csr_wdata` = 0x1880, `csr_we` = 1. Invalid word 0xFFFFFFFF -> `inst_invalid` = 1, all enables 0.
